// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared constants for the pipelined RISC-V core: datapath
//                width, the bubble instruction, default reset PC and the
//                instruction field bit positions used by fetch and decode.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0,x0,0 : decodes as a harmless OP-IMM when inserted as a bubble
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction field positions
    localparam int unsigned OP_LSB       = 0;
    localparam int unsigned OP_MSB       = 6;
    localparam int unsigned RD_LSB       = 7;
    localparam int unsigned RD_MSB       = 11;
    localparam int unsigned FUNCT3_LSB   = 12;
    localparam int unsigned FUNCT3_MSB   = 14;
    localparam int unsigned RS1_LSB      = 15;
    localparam int unsigned RS1_MSB      = 19;
    localparam int unsigned RS2_LSB      = 20;
    localparam int unsigned RS2_MSB      = 24;
    localparam int unsigned FUNCT7B5_BIT = 30;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Bundle of the fetch stage's hazard controls, redirect,
//                instruction-memory port and decode-stage outputs.
//  Ports       : none (signals only)
//    master : fetch stage (drives imem_addr, PCF and all *D / field outputs)
//    slave  : surrounding pipeline (drives stalls, flush, redirect, imem_rdata)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    import riscv_pkg::*;

    // Hazard / redirect controls
    logic            StallF;
    logic            StallD;
    logic            FlushD;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;

    // Instruction memory
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;

    // Fetch / decode outputs
    logic [XLEN-1:0] PCF;
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            validD;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [4:0]      Rs1D;
    logic [4:0]      Rs2D;
    logic [4:0]      RdD;

    modport master (
        input  StallF, StallD, FlushD, PCSrcE, PCTargetE, imem_rdata,
        output imem_addr, PCF, InstrD, PCD, PCPlus4D, validD,
               op, funct3, funct7b5, Rs1D, Rs2D, RdD
    );

    modport slave (
        output StallF, StallD, FlushD, PCSrcE, PCTargetE, imem_rdata,
        input  imem_addr, PCF, InstrD, PCD, PCPlus4D, validD,
               op, funct3, funct7b5, Rs1D, Rs2D, RdD
    );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register. Reset and clear both load a bubble;
//                clear takes priority over a held (disabled) register.
//  Ports       :
//    clk, reset         : clock, synchronous active-high reset
//    i_en               : load enable (low = hold)
//    i_clr              : synchronous clear to bubble
//    i_instr/i_pc/i_pc_plus4 : fetched word, its PC and PC+4
//    o_instr/o_pc/o_pc_plus4/o_valid : registered decode-stage values
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import riscv_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            i_en,
    input  wire logic            i_clr,
    input  wire logic [31:0]     i_instr,
    input  wire logic [XLEN-1:0] i_pc,
    input  wire logic [XLEN-1:0] i_pc_plus4,
    output      logic [31:0]     o_instr,
    output      logic [XLEN-1:0] o_pc,
    output      logic [XLEN-1:0] o_pc_plus4,
    output      logic            o_valid
);

    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic            r_valid;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_en) begin
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage: PC register with next-PC selection
//                (redirect > stall > PC+4), instruction-memory address and the
//                IF/ID register feeding decode, plus decoded field slices.
//  Ports       :
//    clk, reset : clock, synchronous active-high reset
//    bus        : fetch_stage_if.master (hazard controls, redirect, imem port,
//                 PCF, InstrD/PCD/PCPlus4D/validD and field outputs)
//  Parameters  : RESET_PC - PC loaded on reset
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  wire logic      clk,
    input  wire logic      reset,
    fetch_stage_if.master  bus
);

    logic [XLEN-1:0] r_pcf;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_next;
    logic [31:0]     w_instr_d;
    logic [XLEN-1:0] w_pc_d;
    logic [XLEN-1:0] w_pc_plus4_d;
    logic            w_valid_d;

    // Modulo-2^XLEN: FFFF_FFFC wraps to 0
    assign w_pc_plus4 = r_pcf + XLEN'(4);

    // A redirect must not be lost while fetch is stalled, so it outranks StallF.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (bus.PCSrcE) begin
            w_pc_next = {bus.PCTargetE[XLEN-1:2], 2'b00};
        end else if (bus.StallF) begin
            w_pc_next = r_pcf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcf <= RESET_PC;
        end else begin
            r_pcf <= w_pc_next;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .i_en       (~bus.StallD),
        .i_clr      (bus.FlushD),
        .i_instr    (bus.imem_rdata),
        .i_pc       (r_pcf),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (w_instr_d),
        .o_pc       (w_pc_d),
        .o_pc_plus4 (w_pc_plus4_d),
        .o_valid    (w_valid_d)
    );

    assign bus.imem_addr = r_pcf;
    assign bus.PCF       = r_pcf;
    assign bus.InstrD    = w_instr_d;
    assign bus.PCD       = w_pc_d;
    assign bus.PCPlus4D  = w_pc_plus4_d;
    assign bus.validD    = w_valid_d;

    assign bus.op        = w_instr_d[OP_MSB:OP_LSB];
    assign bus.funct3    = w_instr_d[FUNCT3_MSB:FUNCT3_LSB];
    assign bus.funct7b5  = w_instr_d[FUNCT7B5_BIT];
    assign bus.Rs1D      = w_instr_d[RS1_MSB:RS1_LSB];
    assign bus.Rs2D      = w_instr_d[RS2_MSB:RS2_LSB];
    assign bus.RdD       = w_instr_d[RD_MSB:RD_LSB];

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. Memory returns the
//                address as the instruction word. A behavioural model tracks
//                the expected PC and decode-stage contents; a negedge process
//                compares every output, and directed literal checks pin the
//                model at key points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic cmp_en;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(TB_RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word at address A is A
    always_comb bus.imem_rdata = bus.imem_addr;

    // Expected state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pcp4;
    logic        m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock, updating the model from the inputs presented now.
    task automatic tick();
        logic [31:0] n_pc, n_instr, n_pcd, n_pcp4;
        logic        n_valid;
        n_instr = m_instr; n_pcd = m_pcd; n_pcp4 = m_pcp4; n_valid = m_valid;
        if (reset) begin
            n_pc = TB_RESET_PC;
            n_instr = 32'h13; n_pcd = 0; n_pcp4 = 0; n_valid = 0;
        end else begin
            if (bus.PCSrcE)      n_pc = bus.PCTargetE & 32'hFFFF_FFFC;
            else if (bus.StallF) n_pc = m_pc;
            else                 n_pc = m_pc + 32'd4;
            if (bus.FlushD) begin
                n_instr = 32'h13; n_pcd = 0; n_pcp4 = 0; n_valid = 0;
            end else if (!bus.StallD) begin
                n_instr = m_pc;          // memory returns the address
                n_pcd   = m_pc;
                n_pcp4  = m_pc + 32'd4;
                n_valid = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd; m_pcp4 = n_pcp4; m_valid = n_valid;
        cmp_en = 1'b1;
    endtask

    task automatic set_ctl(input logic sf, input logic sd, input logic fd,
                           input logic ps, input logic [31:0] tgt);
        bus.StallF = sf; bus.StallD = sd; bus.FlushD = fd;
        bus.PCSrcE = ps; bus.PCTargetE = tgt;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("PCF",      bus.PCF,               m_pc);
            chk("imem_addr", bus.imem_addr,        m_pc);
            chk("InstrD",   bus.InstrD,            m_instr);
            chk("PCD",      bus.PCD,               m_pcd);
            chk("PCPlus4D", bus.PCPlus4D,          m_pcp4);
            chk("validD",   32'(bus.validD),       32'(m_valid));
            chk("op",       32'(bus.op),           m_instr % 128);
            chk("funct3",   32'(bus.funct3),       (m_instr / 4096) % 8);
            chk("funct7b5", 32'(bus.funct7b5),     (m_instr / (1 << 30)) % 2);
            chk("Rs1D",     32'(bus.Rs1D),         (m_instr / (1 << 15)) % 32);
            chk("Rs2D",     32'(bus.Rs2D),         (m_instr / (1 << 20)) % 32);
            chk("RdD",      32'(bus.RdD),          (m_instr / 128) % 32);
        end
    end

    initial begin
        checks = 0; errors = 0; cmp_en = 1'b0;
        m_pc = 0; m_instr = 0; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
        reset = 1'b1;
        set_ctl(0, 0, 0, 0, 32'h0);

        // Reset state
        tick(); tick();
        chk("rst_PCF",    bus.PCF, 32'h1000);
        chk("rst_InstrD", bus.InstrD, 32'h13);
        chk("rst_validD", 32'(bus.validD), 32'h0);
        chk("rst_op",     32'(bus.op), 32'h13);

        // Free-running fetch
        reset = 1'b0;
        tick();
        chk("run1_PCF",    bus.PCF, 32'h1004);
        chk("run1_InstrD", bus.InstrD, 32'h1000);
        chk("run1_validD", 32'(bus.validD), 32'h1);
        chk("run1_PCP4",   bus.PCPlus4D, 32'h1004);
        tick();
        chk("run2_PCF",    bus.PCF, 32'h1008);
        chk("run2_InstrD", bus.InstrD, 32'h1004);

        // Stall F and D for 3 cycles at PCF=1008
        set_ctl(1, 1, 0, 0, 32'h0);
        repeat (3) tick();
        chk("stall_PCF",    bus.PCF, 32'h1008);
        chk("stall_InstrD", bus.InstrD, 32'h1004);
        set_ctl(0, 0, 0, 0, 32'h0);
        tick();
        chk("rel1_InstrD", bus.InstrD, 32'h1008);
        tick();
        chk("rel2_InstrD", bus.InstrD, 32'h100C);

        // Redirect with flush, unaligned target
        set_ctl(0, 0, 1, 1, 32'h0000_2003);
        tick();
        chk("redir_PCF",    bus.PCF, 32'h2000);
        chk("redir_InstrD", bus.InstrD, 32'h13);
        chk("redir_validD", 32'(bus.validD), 32'h0);
        set_ctl(0, 0, 0, 0, 32'h0);
        tick();
        chk("redir2_InstrD", bus.InstrD, 32'h2000);

        // Redirect beats StallF; flush beats StallD
        set_ctl(1, 1, 1, 1, 32'h0000_3000);
        tick();
        chk("prio_PCF",    bus.PCF, 32'h3000);
        chk("prio_validD", 32'(bus.validD), 32'h0);
        chk("prio_PCD",    bus.PCD, 32'h0);
        set_ctl(0, 0, 0, 0, 32'h0);
        tick();

        // PC wrap-around
        set_ctl(0, 0, 0, 1, 32'hFFFF_FFFE);
        tick();
        chk("wrap0_PCF", bus.PCF, 32'hFFFF_FFFC);
        set_ctl(0, 0, 0, 0, 32'h0);
        tick();
        chk("wrap_PCF",  bus.PCF, 32'h0);
        chk("wrap_PCP4", bus.PCPlus4D, 32'h0);
        tick();

        // D-only stall while fetch advances
        set_ctl(0, 1, 0, 0, 32'h0);
        tick(); tick();
        set_ctl(0, 0, 0, 0, 32'h0);
        tick();

        // Directed control table
        for (int i = 0; i < 24; i++) begin
            set_ctl((i % 5) == 2, ((i % 5) == 2) || ((i % 7) == 3), (i % 6) == 4,
                    (i % 8) == 5, 32'h5000 + 32'(i) * 32'd20 + 32'(i % 4));
            tick();
        end
        set_ctl(0, 0, 0, 0, 32'h0);
        tick();

        // Reset overrides pending stall and redirect
        reset = 1'b1;
        set_ctl(0, 1, 0, 1, 32'h0000_4000);
        tick();
        chk("mrst_PCF",    bus.PCF, 32'h1000);
        chk("mrst_InstrD", bus.InstrD, 32'h13);
        chk("mrst_validD", 32'(bus.validD), 32'h0);
        chk("mrst_PCP4",   bus.PCPlus4D, 32'h0);
        reset = 1'b0;
        set_ctl(0, 0, 0, 0, 32'h0);
        tick(); tick();

        cmp_en = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined RISC-V CPU. Holds the PC, drives the instruction-memory address, and registers the fetched instruction and its PC into the decode stage. Its `op`, `funct3` and `funct7b5` outputs feed the decode-stage controller directly. Applies hazard-unit stalls, branch/jump flushes and execute-stage redirects.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1: single clock, all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `StallF`  in  1: hold PCF.
- `StallD`  in  1: hold IF/ID register.
- `FlushD`  in  1: replace IF/ID contents with a bubble.
- `PCSrcE`  in  1: redirect request from execute (taken branch, jal, jalr).
- `PCTargetE`  in  32: redirect target.
- `imem_addr`  out  32: instruction-memory address (= PCF).
- `imem_rdata`  in  32: instruction word, combinational read of `imem_addr`.
- `PCF`  out  32: current fetch PC.
- `InstrD`  out  32: registered instruction.
- `PCD`  out  32: PC of `InstrD`.
- `PCPlus4D`  out  32: `PCD + 4`, registered.
- `validD`  out  1: `InstrD` is a real fetched instruction (0 for bubbles).
- `op`  out  7: `InstrD[6:0]`.
- `funct3`  out  3: `InstrD[14:12]`.
- `funct7b5`  out  1: `InstrD[30]`.
- `Rs1D`, `Rs2D`, `RdD`  out  5 each: `InstrD[19:15]`, `[24:20]`, `[11:7]`.

## Operation
- PC register next-value priority: reset → `RESET_PC`; else `PCSrcE` → `{PCTargetE[31:2],2'b00}`; else `StallF` → hold; else `PCF + 4`.
- Redirect beats `StallF`: a redirect presented during a stall is taken, not lost.
- PC arithmetic is 32-bit modulo; `32'hFFFF_FFFC + 4` wraps to 0. No misalignment trap; target bits [1:0] are always cleared.
- IF/ID register priority: reset → bubble; else `FlushD` → bubble; else `StallD` → hold all fields; else load `imem_rdata`, `PCF`, `PCF+4`, `validD=1`.
- Bubble: `InstrD = 32'h0000_0013` (addi x0,x0,0), `PCD = 0`, `PCPlus4D = 0`, `validD = 0`. The controller therefore decodes a bubble as a harmless OP-IMM.
- `FlushD` beats `StallD`.
- Field outputs (`op`, `funct3`, `funct7b5`, `Rs*D`, `RdD`) are pure slices of `InstrD` with no extra logic.
- Reset mid-operation: the next edge discards any pending redirect, stall or fetch. Outputs take their reset values.

## Timing
- Reset values: `PCF = imem_addr = RESET_PC`, `InstrD = 32'h0000_0013`, `PCD = 0`, `PCPlus4D = 0`, `validD = 0`, `op = 7'h13`, `funct3 = 0`, `funct7b5 = 0`, `Rs1D = Rs2D = RdD = 0`.
- Fetch-to-decode latency: 1 cycle. The word read at `PCF` in cycle N appears on `InstrD` in cycle N+1.
- Redirect: `PCSrcE` high in cycle N → `PCF = target` in N+1. The external hazard unit asserts `FlushD` in N to kill the wrong-path word.
- Stall: with `StallF = StallD = 1` held for k cycles, `PCF` and all D outputs are frozen for k cycles. Fetch resumes on the first cycle after release with no lost or duplicated instruction.
- Same-cycle `PCSrcE` and `FlushD`: PC loads the target and D becomes a bubble.
- No combinational path from `imem_rdata` to any output. `imem_addr` depends only on registered state.

## Structure
- Shared package `riscv_pkg` holds `NOP_INSTR = 32'h0000_0013`, `XLEN = 32`, default `RESET_PC`, and the instruction field bit positions (opcode, funct3, funct7b5, rs1, rs2, rd) used here and by decode.
- One sub-module: `if_id_reg`, the IF/ID register with enable (`~StallD`), synchronous clear (`FlushD`) and reset-to-bubble. The PC register and next-PC mux stay in `fetch_stage`.

## Test plan
- Reset with `RESET_PC = 32'h0000_1000`, no stalls, memory returning `instr = addr`: after release, `PCF` steps 1000, 1004, 1008. `InstrD` lags by one cycle, `validD` rises on the first post-reset edge, `PCPlus4D = PCD + 4`.
- `StallF = StallD = 1` for 3 cycles at `PCF = 32'h1008`: `PCF` and `InstrD` are frozen. After release the next `InstrD` is the word from `1008`, then `100C`.
- `PCSrcE = 1`, `PCTargetE = 32'h0000_2003`, `FlushD = 1` in the same cycle: next cycle `PCF = 32'h2000`, `InstrD = 32'h13`, `validD = 0`. The following cycle `InstrD` is the word from `2000`.
- `PCSrcE = 1` together with `StallF = 1`, target `32'h3000`: `PCF = 32'h3000` next cycle (redirect wins). `FlushD` and `StallD` both high: D becomes a bubble (flush wins).
- `PCF = 32'hFFFF_FFFC`, no stall: next `PCF = 0`.
- Assert `reset` while `StallD` is held and `PCSrcE = 1`: next cycle every output equals its reset value.
